se_host_sequencer: RTL and testbench

- Command sequencer directly upstream of the secure-element top. Drives its i_data_in / i_add / i_control and consumes o_data_out / o_end_op.
- Accepts one host command (module select, input word count, output word count), then sequences the core:
  - reset,
  - streamed message load,
  - start,
  - wait for end_op,
  - digest readback as a ready/valid stream.
- Removes per-word software polling from the hash path.

---
 rtl/se_seq_pkg.sv | 34 +++
 rtl/se_seq_timeout.sv | 27 ++
 rtl/se_host_sequencer.sv | 207 ++++++++++++++++++++
 tb/tb_se_host_sequencer.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/se_seq_pkg.sv
// Shared control codes, module addresses and state encoding
// for the secure-element host sequencers.
package se_seq_pkg;

    localparam logic [31:0] CTRL_IDLE  = 32'd0;
    localparam logic [31:0] CTRL_RESET = 32'd1;
    localparam logic [31:0] CTRL_LOAD  = 32'd2;
    localparam logic [31:0] CTRL_START = 32'd3;
    localparam logic [31:0] CTRL_READ  = 32'd4;

    localparam logic [31:0] ADDR_SHA2 = 32'h20;
    localparam logic [31:0] ADDR_SHA3 = 32'h30;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RSTC,
        S_LOAD,
        S_START,
        S_WAIT,
        S_RADDR,
        S_RDATA
    } state_t;

    typedef struct packed {
        logic [31:0] mod;
        logic [7:0]  nwords;
        logic [3:0]  nout;
    } cmd_t;

    function automatic logic [63:0] zext_idx(input logic [7:0] idx);
        return {56'd0, idx};
    endfunction

endpackage

// File: rtl/se_seq_timeout.sv
// Loadable down-counter; o_expired is high while the count is zero.
module se_seq_timeout #(
    parameter int W = 16
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_en,
    output logic         o_expired
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            cnt_q <= '0;
        end else if (i_load) begin
            cnt_q <= i_load_val;
        end else if (i_en && cnt_q != '0) begin
            cnt_q <= cnt_q - W'(1);
        end
    end

    assign o_expired = (cnt_q == '0);

endmodule

// File: rtl/se_host_sequencer.sv
// Host command sequencer: reset, streamed load, start, wait and
// digest readback of the secure-element core.
module se_host_sequencer
    import se_seq_pkg::*;
#(
    parameter int RST_CYCLES     = 2,
    parameter int TIMEOUT_CYCLES = 65535,
    parameter int TO_W           = 16
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_cmd_valid,
    output logic        o_cmd_ready,
    input  logic [31:0] i_cmd_module,
    input  logic [7:0]  i_cmd_nwords,
    input  logic [3:0]  i_cmd_nout,
    input  logic        i_wr_valid,
    input  logic [63:0] i_wr_data,
    output logic        o_wr_ready,
    output logic        o_rd_valid,
    output logic [63:0] o_rd_data,
    input  logic        i_rd_ready,
    output logic        o_busy,
    output logic        o_err,
    output logic [63:0] o_se_data_in,
    output logic [63:0] o_se_add,
    output logic [63:0] o_se_control,
    input  logic [63:0] i_se_data_out,
    input  logic        i_se_end_op
);

    localparam logic [7:0] RST_LAST = 8'(RST_CYCLES - 1);

    state_t      state_q, state_n;
    cmd_t        cmd_q, cmd_n;
    logic [7:0]  idx_q, idx_n, idx_inc;
    logic [7:0]  rst_cnt_q, rst_cnt_n;
    logic        first_q, first_n;
    logic        abort_q, abort_n;
    logic        err_q, err_n;
    logic [63:0] data_q, data_n;
    logic [63:0] add_q, add_n;
    logic [31:0] ctrl_q, ctrl_n;
    logic [63:0] rd_data_q, rd_data_n;
    logic        rd_valid_q, rd_valid_n;
    logic        to_load, to_en, to_expired;
    logic        wr_hs;

    se_seq_timeout #(
        .W(TO_W)
    ) u_timeout (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_load     (to_load),
        .i_load_val (TO_W'(TIMEOUT_CYCLES)),
        .i_en       (to_en),
        .o_expired  (to_expired)
    );

    assign o_cmd_ready  = (state_q == S_IDLE);
    assign o_busy       = (state_q != S_IDLE);
    assign o_wr_ready   = (state_q == S_LOAD) && (idx_q != cmd_q.nwords);
    assign wr_hs        = o_wr_ready && i_wr_valid;
    assign idx_inc      = idx_q + 8'd1;
    assign o_rd_valid   = rd_valid_q;
    assign o_rd_data    = rd_data_q;
    assign o_err        = err_q;
    assign o_se_data_in = data_q;
    assign o_se_add     = add_q;
    assign o_se_control = {cmd_q.mod, ctrl_q};

    // Output registers carry the action of the state being entered,
    // except load pulses which follow their handshake by one cycle.
    always_comb begin
        state_n    = state_q;
        cmd_n      = cmd_q;
        idx_n      = idx_q;
        rst_cnt_n  = rst_cnt_q;
        first_n    = 1'b0;
        abort_n    = 1'b0;
        err_n      = 1'b0;
        data_n     = '0;
        add_n      = '0;
        ctrl_n     = CTRL_IDLE;
        rd_data_n  = rd_data_q;
        rd_valid_n = rd_valid_q;
        to_load    = 1'b0;
        to_en      = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (i_cmd_valid) begin
                    cmd_n     = '{i_cmd_module, i_cmd_nwords, i_cmd_nout};
                    idx_n     = '0;
                    rst_cnt_n = '0;
                    ctrl_n    = CTRL_RESET;
                    state_n   = S_RSTC;
                end
            end
            S_RSTC: begin
                if (rst_cnt_q == RST_LAST) begin
                    if (cmd_q.nwords != '0) begin
                        state_n = S_LOAD;
                    end else begin
                        state_n = S_START;
                        ctrl_n  = CTRL_START;
                    end
                end else begin
                    rst_cnt_n = rst_cnt_q + 8'd1;
                    ctrl_n    = CTRL_RESET;
                end
            end
            S_LOAD: begin
                if (wr_hs) begin
                    data_n = i_wr_data;
                    add_n  = zext_idx(idx_q);
                    ctrl_n = CTRL_LOAD;
                    idx_n  = idx_inc;
                end else if (idx_q == cmd_q.nwords) begin
                    idx_n   = '0;
                    ctrl_n  = CTRL_START;
                    state_n = S_START;
                end
            end
            S_START: begin
                to_load = 1'b1;
                first_n = 1'b1;
                state_n = S_WAIT;
            end
            S_WAIT: begin
                to_en = 1'b1;
                if (abort_q) begin
                    cmd_n.mod = '0;
                    state_n   = S_IDLE;
                end else if (err_q) begin
                    ctrl_n  = CTRL_RESET;
                    abort_n = 1'b1;
                end else if (first_q) begin
                    // end_op may still be set from the previous job
                    state_n = S_WAIT;
                end else if (i_se_end_op) begin
                    if (cmd_q.nout != '0) begin
                        idx_n   = '0;
                        add_n   = '0;
                        ctrl_n  = CTRL_READ;
                        state_n = S_RADDR;
                    end else begin
                        cmd_n.mod = '0;
                        state_n   = S_IDLE;
                    end
                end else if (to_expired) begin
                    err_n = 1'b1;
                end
            end
            S_RADDR: begin
                rd_data_n  = i_se_data_out;
                rd_valid_n = 1'b1;
                state_n    = S_RDATA;
            end
            S_RDATA: begin
                if (i_rd_ready) begin
                    rd_valid_n = 1'b0;
                    if (idx_inc == {4'd0, cmd_q.nout}) begin
                        cmd_n.mod = '0;
                        state_n   = S_IDLE;
                    end else begin
                        idx_n   = idx_inc;
                        add_n   = zext_idx(idx_inc);
                        ctrl_n  = CTRL_READ;
                        state_n = S_RADDR;
                    end
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            state_q    <= S_IDLE;
            cmd_q      <= '0;
            idx_q      <= '0;
            rst_cnt_q  <= '0;
            first_q    <= 1'b0;
            abort_q    <= 1'b0;
            err_q      <= 1'b0;
            data_q     <= '0;
            add_q      <= '0;
            ctrl_q     <= CTRL_IDLE;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_n;
            cmd_q      <= cmd_n;
            idx_q      <= idx_n;
            rst_cnt_q  <= rst_cnt_n;
            first_q    <= first_n;
            abort_q    <= abort_n;
            err_q      <= err_n;
            data_q     <= data_n;
            add_q      <= add_n;
            ctrl_q     <= ctrl_n;
            rd_data_q  <= rd_data_n;
            rd_valid_q <= rd_valid_n;
        end
    end

endmodule

// File: tb/tb_se_host_sequencer.sv
// Scoreboard bench for se_host_sequencer with a behavioural core model.
module tb_se_host_sequencer;
    import se_seq_pkg::*;

    typedef struct {
        logic [63:0] ctl;
        logic [63:0] add;
        logic [63:0] dat;
    } ev_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [31:0] cmd_module;
    logic [7:0]  cmd_nwords;
    logic [3:0]  cmd_nout;
    logic        wr_valid;
    logic [63:0] wr_data;
    logic        wr_ready;
    logic        rd_valid;
    logic [63:0] rd_data;
    logic        rd_ready;
    logic        busy;
    logic        err;
    logic [63:0] se_din;
    logic [63:0] se_add;
    logic [63:0] se_ctl;
    logic [63:0] se_dout;
    logic        se_eop;

    int checks = 0;
    int fails  = 0;
    int cyc    = 0;
    int start_cyc = 0;
    int read_cyc  = 0;
    int last_rst_cyc = 0;
    int err_cnt = 0;
    int rdv_cnt = 0;

    ev_t         exp_ctl[$];
    logic [63:0] exp_rd[$];

    logic [1:0] mode = 2'd0;
    logic       run  = 1'b0;
    int         ccnt = 0;

    always #5 clk = ~clk;

    se_host_sequencer #(
        .RST_CYCLES     (2),
        .TIMEOUT_CYCLES (20),
        .TO_W           (16)
    ) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_cmd_valid   (cmd_valid),
        .o_cmd_ready   (cmd_ready),
        .i_cmd_module  (cmd_module),
        .i_cmd_nwords  (cmd_nwords),
        .i_cmd_nout    (cmd_nout),
        .i_wr_valid    (wr_valid),
        .i_wr_data     (wr_data),
        .o_wr_ready    (wr_ready),
        .o_rd_valid    (rd_valid),
        .o_rd_data     (rd_data),
        .i_rd_ready    (rd_ready),
        .o_busy        (busy),
        .o_err         (err),
        .o_se_data_in  (se_din),
        .o_se_add      (se_add),
        .o_se_control  (se_ctl),
        .i_se_data_out (se_dout),
        .i_se_end_op   (se_eop)
    );

    function automatic logic [63:0] digest(input logic [31:0] m, input logic [7:0] a);
        if (m == ADDR_SHA3) return 64'h3a3a_0000_0000_0000 | {56'd0, a};
        if (m == ADDR_SHA2) return 64'h2b2b_0000_0000_0000 | {56'd0, a};
        return '1;
    endfunction

    function automatic logic [63:0] wdata(input int i);
        return 64'hc0de_0000_0000_0000 | 64'(i * 7 + 1);
    endfunction

    // Core model: end_op 10 cycles after START (mode 0), stuck high (1) or never (2)
    always @(posedge clk) begin
        if (se_ctl[31:0] == CTRL_START) begin
            run  <= 1'b1;
            ccnt <= 0;
        end else if (se_ctl[31:0] == CTRL_RESET) begin
            run  <= 1'b0;
            ccnt <= 0;
        end else if (run && ccnt < 1000) begin
            ccnt <= ccnt + 1;
        end
    end

    assign se_eop  = (mode == 2'd1) ? 1'b1 :
                     (mode == 2'd0) ? (run && ccnt >= 10) : 1'b0;
    assign se_dout = (se_ctl[31:0] == CTRL_READ) ?
                     digest(se_ctl[63:32], se_add[7:0]) : 64'd0;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%h exp=%h", nm, got, exp);
        end
    endtask

    // Monitor: every non-idle control cycle and every read handshake pops the scoreboard
    always @(negedge clk) begin
        ev_t e;
        cyc++;
        if (se_ctl[31:0] != CTRL_IDLE) begin
            if (se_ctl[31:0] == CTRL_START) start_cyc = cyc;
            if (se_ctl[31:0] == CTRL_RESET) last_rst_cyc = cyc;
            if (se_ctl[31:0] == CTRL_READ && read_cyc < start_cyc) read_cyc = cyc;
            if (exp_ctl.size() == 0) begin
                checks++;
                fails++;
                $display("FAIL ctl_unexpected got=%h add=%h", se_ctl, se_add);
            end else begin
                e = exp_ctl.pop_front();
                chk("se_control", se_ctl, e.ctl);
                chk("se_add", se_add, e.add);
                chk("se_data_in", se_din, e.dat);
            end
        end
        if (rd_valid && rd_ready) begin
            if (exp_rd.size() == 0) begin
                checks++;
                fails++;
                $display("FAIL rd_unexpected got=%h", rd_data);
            end else begin
                chk("rd_data", rd_data, exp_rd.pop_front());
            end
        end
        if (err) err_cnt++;
        if (rd_valid) rdv_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        @(negedge clk);
        while (busy && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (busy) chk("idle_timeout", 64'(busy), 64'd0);
        tick();
    endtask

    task automatic push_ctl(input logic [31:0] m, input logic [31:0] c,
                            input int a, input logic [63:0] d);
        exp_ctl.push_back('{ {m, c}, 64'(a), d });
    endtask

    task automatic issue(input logic [31:0] m, input int nw, input int no);
        int n = 0;
        @(negedge clk);
        while (!cmd_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) chk("cmd_ready_timeout", 64'(cmd_ready), 64'd1);
        cmd_valid  = 1'b1;
        cmd_module = m;
        cmd_nwords = 8'(nw);
        cmd_nout   = 4'(no);
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic send_word(input int i);
        logic r;
        int   n = 0;
        wr_valid = 1'b1;
        wr_data  = wdata(i);
        forever begin
            @(negedge clk);
            r = wr_ready;
            tick();
            n++;
            if (r || n > 50) break;
        end
        if (!r) chk("wr_ready_timeout", 64'(r), 64'd1);
        wr_valid = 1'b0;
    endtask

    task automatic run_cmd(input logic [31:0] m, input int nw, input int no,
                           input bit gap, input bit abort);
        push_ctl(m, CTRL_RESET, 0, 64'd0);
        push_ctl(m, CTRL_RESET, 0, 64'd0);
        for (int i = 0; i < nw; i++) push_ctl(m, CTRL_LOAD, i, wdata(i));
        push_ctl(m, CTRL_START, 0, 64'd0);
        if (abort) begin
            push_ctl(m, CTRL_RESET, 0, 64'd0);
        end else begin
            for (int i = 0; i < no; i++) begin
                push_ctl(m, CTRL_READ, i, 64'd0);
                exp_rd.push_back(digest(m, 8'(i)));
            end
        end
        issue(m, nw, no);
        for (int i = 0; i < nw; i++) begin
            send_word(i);
            if (gap && (i % 4 == 3)) repeat (2) tick();
        end
    endtask

    initial begin
        int e0;
        int r0;
        rst        = 1'b0;
        cmd_valid  = 1'b0;
        cmd_module = '0;
        cmd_nwords = '0;
        cmd_nout   = '0;
        wr_valid   = 1'b0;
        wr_data    = '0;
        rd_ready   = 1'b1;
        repeat (3) tick();
        rst = 1'b1;
        @(negedge clk);
        chk("rst_cmd_ready", 64'(cmd_ready), 64'd1);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_se_control", se_ctl, 64'd0);
        chk("rst_rd_valid", 64'(rd_valid), 64'd0);
        chk("rst_rd_data", rd_data, 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        tick();

        // SHA3, 3 words in, 2 out, end_op 10 cycles after START
        run_cmd(ADDR_SHA3, 3, 2, 1'b0, 1'b0);
        wait_idle(200);
        chk("sha3_start_to_read", 64'(read_cyc - start_cyc), 64'd12);
        chk("sha3_rd_drained", 64'(exp_rd.size()), 64'd0);

        // Back-pressure on the first output word, busy command refused
        rd_ready = 1'b0;
        run_cmd(ADDR_SHA3, 2, 3, 1'b0, 1'b0);
        begin
            int n = 0;
            @(negedge clk);
            while (!rd_valid && n < 200) begin
                @(negedge clk);
                n++;
            end
        end
        cmd_valid  = 1'b1;
        cmd_module = 32'h99;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            chk("bp_rd_valid", 64'(rd_valid), 64'd1);
            chk("bp_rd_data", rd_data, digest(ADDR_SHA3, 8'd0));
        end
        chk("busy_cmd_ready", 64'(cmd_ready), 64'd0);
        tick();
        cmd_valid = 1'b0;
        rd_ready  = 1'b1;
        wait_idle(200);

        // Stale end_op: held high through START, accepted on 2nd WAIT cycle
        mode = 2'd1;
        run_cmd(ADDR_SHA2, 1, 1, 1'b0, 1'b0);
        wait_idle(200);
        chk("stale_start_to_read", 64'(read_cyc - start_cyc), 64'd3);
        mode = 2'd0;

        // Timeout: end_op never rises
        mode = 2'd2;
        e0 = err_cnt;
        r0 = rdv_cnt;
        run_cmd(ADDR_SHA3, 0, 2, 1'b0, 1'b1);
        wait_idle(200);
        chk("to_err_pulses", 64'(err_cnt - e0), 64'd1);
        chk("to_rd_valid", 64'(rdv_cnt - r0), 64'd0);
        chk("to_start_to_reset", 64'(last_rst_cyc - start_cyc), 64'd23);
        mode = 2'd0;

        // Empty command: RSTC, START, WAIT, IDLE
        run_cmd(ADDR_SHA2, 0, 0, 1'b0, 1'b0);
        wait_idle(200);
        chk("empty_reset_to_start", 64'(start_cyc - last_rst_cyc), 64'd1);

        // 255 words with gaps in wr_valid
        run_cmd(ADDR_SHA2, 255, 0, 1'b1, 1'b0);
        wait_idle(2000);

        // Unknown module: all-ones digest
        run_cmd(32'h55, 1, 2, 1'b0, 1'b0);
        wait_idle(200);
        chk("unk_rd_drained", 64'(exp_rd.size()), 64'd0);

        // Reset while word 2 of 4 is presented
        push_ctl(ADDR_SHA3, CTRL_RESET, 0, 64'd0);
        push_ctl(ADDR_SHA3, CTRL_RESET, 0, 64'd0);
        push_ctl(ADDR_SHA3, CTRL_LOAD, 0, wdata(0));
        push_ctl(ADDR_SHA3, CTRL_LOAD, 1, wdata(1));
        issue(ADDR_SHA3, 4, 1);
        send_word(0);
        send_word(1);
        wr_valid = 1'b1;
        wr_data  = wdata(2);
        rst      = 1'b0;
        tick();
        rst      = 1'b1;
        wr_valid = 1'b0;
        @(negedge clk);
        chk("mid_rst_se_control", se_ctl, 64'd0);
        chk("mid_rst_se_add", se_add, 64'd0);
        chk("mid_rst_se_data_in", se_din, 64'd0);
        chk("mid_rst_busy", 64'(busy), 64'd0);
        chk("mid_rst_cmd_ready", 64'(cmd_ready), 64'd1);
        repeat (3) tick();

        chk("ctl_drained", 64'(exp_ctl.size()), 64'd0);
        chk("rd_drained", 64'(exp_rd.size()), 64'd0);
        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
